shim_shutdown_sense_ctrl: RTL

SHIM_SHUTDOWN_SENSE_CTRL -- requirements
Module: shim_shutdown_sense_ctrl

---
 rtl/shim_shutdown_sense_ctrl_if.sv | 34 +++
 rtl/shim_shutdown_sense_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/shim_shutdown_sense_ctrl_if.sv
// rtl/shim_shutdown_sense_ctrl_if.sv - control, sense-mux and fault-status bundle for the shutdown sense scanner
// first_fault is present only when SHUTDOWN_SENSE_FIRST_FAULT_EN is defined.
interface shim_shutdown_sense_ctrl_if;
  logic       enable;
  logic [7:0] channel_mask;
  logic       clear;
  logic       sense_pin;
  logic [2:0] sense_sel;
  logic [7:0] fault;
  logic       fault_any;
  logic       fault_irq;
  logic       scan_done;
`ifdef SHUTDOWN_SENSE_FIRST_FAULT_EN
  logic [3:0] first_fault;

  modport master (
    output enable, channel_mask, clear, sense_pin,
    input  sense_sel, fault, fault_any, fault_irq, scan_done, first_fault
  );
  modport slave (
    input  enable, channel_mask, clear, sense_pin,
    output sense_sel, fault, fault_any, fault_irq, scan_done, first_fault
  );
`else
  modport master (
    output enable, channel_mask, clear, sense_pin,
    input  sense_sel, fault, fault_any, fault_irq, scan_done
  );
  modport slave (
    input  enable, channel_mask, clear, sense_pin,
    output sense_sel, fault, fault_any, fault_irq, scan_done
  );
`endif
endinterface

// File: rtl/shim_shutdown_sense_ctrl.sv
// rtl/shim_shutdown_sense_ctrl.sv - 8-channel muxed shutdown-sense scanner with filtered sticky faults
// Optional first-fault capture enabled by SHUTDOWN_SENSE_FIRST_FAULT_EN.
module shim_shutdown_sense_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int FILTER_COUNT  = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  shim_shutdown_sense_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;

  localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] FILTER_MAX    = 4'(FILTER_COUNT);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] hit_q [8];
  logic [3:0] hit_d [8];
  logic [7:0] reach_q, reach_d;
  logic [7:0] fault_q, fault_d;
  logic [7:0] fault_base;
  logic       fault_any_q, fault_any_d;
  logic       fault_irq_q, fault_irq_d;
  logic       scan_done_q, scan_done_d;

  always_comb begin
    sync1_d     = bus.sense_pin;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    hit_d       = hit_q;
    reach_d     = '0;
    scan_done_d = 1'b0;

    if (!bus.enable) begin
      state_d = ST_IDLE;
      sel_d   = 3'd0;
      cnt_d   = SETTLE_RELOAD;
      for (int i = 0; i < 8; i++) hit_d[i] = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_RELOAD;
          sel_d   = 3'd0;
        end
        ST_SETTLE: begin
          if (cnt_q == 8'd0) state_d = ST_SAMPLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
        ST_SAMPLE: begin
          for (int i = 0; i < 8; i++) begin
            if (!bus.channel_mask[i]) hit_d[i] = '0;
          end
          // reach fires on every high sample at the threshold, so a channel still
          // asserting after a clear re-latches on its next visit
          if (bus.channel_mask[sel_q]) begin
            if (sync2_q) begin
              if (hit_q[sel_q] < FILTER_MAX) hit_d[sel_q] = hit_q[sel_q] + 4'd1;
              if (hit_d[sel_q] == FILTER_MAX) reach_d[sel_q] = 1'b1;
            end else begin
              hit_d[sel_q] = '0;
            end
          end
          sel_d       = sel_q + 3'd1;
          cnt_d       = SETTLE_RELOAD;
          state_d     = ST_SETTLE;
          scan_done_d = (sel_q == 3'd7);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // a latch arriving together with clear still sets its bit and raises the irq
  always_comb begin
    fault_base  = bus.clear ? 8'h00 : fault_q;
    fault_d     = fault_base | reach_q;
    fault_any_d = |fault_d;
    fault_irq_d = |(reach_q & ~fault_base);
  end

`ifdef SHUTDOWN_SENSE_FIRST_FAULT_EN
  logic [3:0] first_q, first_d;

  always_comb begin
    first_d = bus.clear ? 4'h0 : first_q;
    if (!first_d[3] && (|reach_q)) begin
      for (int i = 7; i >= 0; i--) begin
        if (reach_q[i]) first_d = {1'b1, 3'(i)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) first_q <= '0;
    else         first_q <= first_d;
  end

  assign bus.first_fault = first_q;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      for (int i = 0; i < 8; i++) hit_q[i] <= '0;
      reach_q     <= '0;
      fault_q     <= '0;
      fault_any_q <= 1'b0;
      fault_irq_q <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      for (int i = 0; i < 8; i++) hit_q[i] <= hit_d[i];
      reach_q     <= reach_d;
      fault_q     <= fault_d;
      fault_any_q <= fault_any_d;
      fault_irq_q <= fault_irq_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign bus.sense_sel = sel_q;
  assign bus.fault     = fault_q;
  assign bus.fault_any = fault_any_q;
  assign bus.fault_irq = fault_irq_q;
  assign bus.scan_done = scan_done_q;

endmodule
